// File: rtl/bgd_acc_pkg.sv
// Shared default widths, FSM encoding and saturation helpers for the BGD dot-product accumulator.
package bgd_acc_pkg;

  localparam int DEF_DATA_W      = 13;
  localparam int DEF_ACC_W       = 24;
  localparam int DEF_OUT_W       = 13;
  localparam int DEF_FRAC_SHIFT  = 0;
  localparam int DEF_MUL_LATENCY = 3;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } acc_state_t;

  // Largest / smallest value representable in a w-bit two's-complement word.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/bgd_vld_tracker.sv
// {vld,last} shift register mirroring the multiplier pipeline; advances only while ce is high
// so the tail entry always lines up with the product currently on the multiplier output.
module bgd_vld_tracker #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic in_vld,
  input  logic in_last,
  output logic tail_vld,
  output logic tail_last,
  output logic any_vld
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] last_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] last_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // last is only meaningful for a real element
        assign vld_d[gi]  = in_vld;
        assign last_d[gi] = in_vld & in_last;
      end else begin : g_body
        assign vld_d[gi]  = vld_q[gi-1];
        assign last_d[gi] = last_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (ce) begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign tail_vld  = vld_q[DEPTH-1];
  assign tail_last = last_q[DEPTH-1];
  assign any_vld   = |vld_q;

endmodule

// File: rtl/bgd_dot_accumulator.sv
// Accumulates BGD multiplier products over one vector and hands the scaled dot product to the sigmoid stage.
// Optional macro BGD_ACC_SAT_EN: saturating accumulate/narrow with a sticky per-vector out_sat flag.
module bgd_dot_accumulator
  import bgd_acc_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int FRAC_SHIFT  = DEF_FRAC_SHIFT,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     issue_vld,
  input  logic                     issue_last,
  output logic                     mul_ce,
  input  logic signed [DATA_W-1:0] prod_in,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     out_sat,
  output logic                     busy
);

  logic                    stall;
  logic                    tail_vld;
  logic                    tail_last;
  logic                    trk_any;
  logic                    take;
  logic                    take_last;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] narrowed;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    out_vld_q, out_vld_d;
  logic                    act_q, act_d;
  acc_state_t              state_q, state_d;

  // Backpressure freezes the multiplier and the tracker together.
  assign stall     = out_vld_q & ~out_rdy;
  assign mul_ce    = en & ~stall;
  assign take      = tail_vld & mul_ce;
  assign take_last = take & tail_last;

  bgd_vld_tracker #(
    .DEPTH (MUL_LATENCY)
  ) u_trk (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (mul_ce),
    .in_vld    (issue_vld),
    .in_last   (issue_last),
    .tail_vld  (tail_vld),
    .tail_last (tail_last),
    .any_vld   (trk_any)
  );

`ifdef BGD_ACC_SAT_EN
  localparam logic signed [ACC_W:0]   ACC_MAX_W = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0]   ACC_MIN_W = (ACC_W+1)'(sat_min(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_W'(sat_min(ACC_W));
  localparam logic signed [ACC_W-1:0] NAR_MAX   = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] NAR_MIN   = ACC_W'(sat_min(OUT_W));

  logic signed [ACC_W:0]   wide_sum;
  logic signed [ACC_W-1:0] shifted;
  logic                    add_clip;
  logic                    nar_clip;
  logic                    clip_q, clip_d;
  logic                    out_sat_q, out_sat_d;

  always_comb begin
    wide_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-DATA_W+1){prod_in[DATA_W-1]}}, prod_in};
    add_clip = 1'b0;
    sum      = wide_sum[ACC_W-1:0];
    if (wide_sum > ACC_MAX_W) begin
      sum      = ACC_MAX;
      add_clip = 1'b1;
    end else if (wide_sum < ACC_MIN_W) begin
      sum      = ACC_MIN;
      add_clip = 1'b1;
    end
    shifted  = sum >>> FRAC_SHIFT;
    nar_clip = 1'b0;
    narrowed = shifted[OUT_W-1:0];
    if (shifted > NAR_MAX) begin
      narrowed = OUT_W'(sat_max(OUT_W));
      nar_clip = 1'b1;
    end else if (shifted < NAR_MIN) begin
      narrowed = OUT_W'(sat_min(OUT_W));
      nar_clip = 1'b1;
    end
  end

  // Clip history is sticky across the vector and handed to out_sat when the result loads.
  always_comb begin
    clip_d    = clip_q;
    out_sat_d = out_sat_q;
    if (take_last) begin
      clip_d    = 1'b0;
      out_sat_d = clip_q | add_clip | nar_clip;
    end else if (take) begin
      clip_d = clip_q | add_clip;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clip_q    <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      clip_q    <= clip_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_sat = out_sat_q;
`else
  always_comb begin
    sum      = acc_q + {{(ACC_W-DATA_W){prod_in[DATA_W-1]}}, prod_in};
    narrowed = OUT_W'(sum >>> FRAC_SHIFT);
  end

  assign out_sat = 1'b0;
`endif

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    out_vld_d  = out_vld_q;
    if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
    // A last load wins over the handshake clear, so back-to-back results have no bubble.
    if (take_last) begin
      acc_d      = '0;
      cnt_d      = '0;
      act_d      = 1'b0;
      out_data_d = narrowed;
      out_cnt_d  = cnt_q + CNT_W'(1);
      out_vld_d  = 1'b1;
    end else if (take) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
      act_d = 1'b1;
    end
    if (out_vld_d) begin
      state_d = OUT;
    end else if (act_d) begin
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      act_q      <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      state_q    <= IDLE;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
      out_vld_q  <= out_vld_d;
      state_q    <= state_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_cnt  = out_cnt_q;
  assign busy     = (state_q != IDLE) | trk_any;

endmodule
